// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and sizing helper for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} arb_state_e;
  function automatic int grant_width(input int channels);
    return channels > 1 ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after rr_ptr
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int CHANNELS = 2,
  localparam int GW = grant_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GW-1:0]       rr_ptr,
  output logic                any_req,
  output logic [GW-1:0]       grant
);
  int idx;
  assign any_req = |req;
  // scanning offsets downwards lets the nearest offset overwrite farther ones
  always_comb begin
    grant = '0;
    idx = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      if (req[idx]) grant = GW'(idx);
    end
  end
endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin arbiter of CHANNELS requesters onto one RAM port
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int BUS_WIDTH_BYTES = 256,
  parameter int ADDR_WIDTH = 32,
  localparam int DW = BUS_WIDTH_BYTES * 8,
  localparam int GW = grant_width(CHANNELS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_address,
  input  logic [CHANNELS-1:0]          ch_read,
  input  logic [CHANNELS-1:0]          ch_write,
  input  logic [CHANNELS*DW-1:0]       ch_wdata,
  output logic [CHANNELS-1:0]          ch_ready,
  output logic [CHANNELS-1:0]          ch_done,
  output logic [DW-1:0]                ch_rdata,
  output logic [ADDR_WIDTH-1:0]        ram_address,
  output logic                         ram_read,
  output logic                         ram_write,
  output logic [DW-1:0]                ram_wdata,
  input  logic [DW-1:0]                ram_rdata,
  input  logic                         ram_ready,
  input  logic                         ram_done
);
  arb_state_e state, next_state;
  logic [GW-1:0] grant, pick, rr_ptr;
  logic any_req, launch, finish;
  logic [CHANNELS-1:0] req;
  assign req = ch_read | ch_write;
  assign launch = state == IDLE && any_req && ram_ready;
  assign finish = state == BUSY && ram_done;
  rr_picker #(.CHANNELS(CHANNELS)) u_picker (
    .req(req),
    .rr_ptr(rr_ptr),
    .any_req(any_req),
    .grant(pick)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = launch ? BUSY : finish ? RESPOND : state == RESPOND ? IDLE : state;
  end
  always_comb begin
    ch_ready = {CHANNELS{state == IDLE}};
  end
  // read wins over write when a channel raises both
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant <= '0;
      rr_ptr <= '0;
      ram_address <= '0;
      ram_wdata <= '0;
      ram_read <= 1'b0;
      ram_write <= 1'b0;
      ch_rdata <= '0;
      ch_done <= '0;
    end else begin
      ch_done <= '0;
      if (launch) begin
        grant <= pick;
        ram_address <= ch_address[pick*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata <= ch_wdata[pick*DW +: DW];
        ram_read <= ch_read[pick];
        ram_write <= !ch_read[pick];
      end
      if (finish) begin
        ch_rdata <= ram_rdata;
        ram_read <= 1'b0;
        ram_write <= 1'b0;
        rr_ptr <= grant == GW'(CHANNELS - 1) ? '0 : grant + GW'(1);
        ch_done <= CHANNELS'(1) << grant;
      end
    end
  end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: transaction-level model check plus directed scenarios
module tb_memory_bus_arbiter;
  localparam int C = 4, BWB = 4, DW = BWB * 8, AW = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [C*AW-1:0] ch_address;
  logic [C-1:0] ch_read, ch_write, ch_ready, ch_done;
  logic [C*DW-1:0] ch_wdata;
  logic [DW-1:0] ch_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_address;
  logic ram_read, ram_write, ram_ready, ram_done;
  int checks = 0, failures = 0;
  bit m_act, m_rd;
  int m_ch, m_done, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int done_log[$];
  bit pending[C];

  always #5 clock = ~clock;

  memory_bus_arbiter #(.CHANNELS(C), .BUS_WIDTH_BYTES(BWB), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write), .ch_wdata(ch_wdata),
    .ch_ready(ch_ready), .ch_done(ch_done), .ch_rdata(ch_rdata),
    .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .ram_done(ram_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_rd = 0; m_ch = 0; m_done = -1; m_ptr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  // one transaction record: granted, in flight, or being reported back
  task automatic model_step();
    int c;
    if (m_done >= 0) m_done = -1;
    else if (m_act) begin
      if (ram_done) begin
        m_rdata = ram_rdata; m_done = m_ch; m_ptr = (m_ch + 1) % C; m_act = 0;
      end
    end else if (ram_ready) begin
      for (int k = 0; k < C; k++) begin
        c = (m_ptr + k) % C;
        if (ch_read[c] || ch_write[c]) begin
          m_act = 1; m_ch = c; m_rd = ch_read[c];
          m_addr = ch_address[c*AW +: AW]; m_wdata = ch_wdata[c*DW +: DW];
          break;
        end
      end
    end
  endtask

  task automatic compare();
    chk("ch_ready", ch_ready, (!m_act && m_done < 0) ? 64'((1 << C) - 1) : 64'd0);
    chk("ch_done", ch_done, m_done >= 0 ? (64'd1 << m_done) : 64'd0);
    chk("ch_rdata", ch_rdata, m_rdata);
    chk("ram_address", ram_address, m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("ram_read", ram_read, m_act && m_rd);
    chk("ram_write", ram_write, m_act && !m_rd);
    for (int i = 0; i < C; i++) if (ch_done[i]) done_log.push_back(i);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_read[i] = rd; ch_write[i] = wr;
    ch_address[i*AW +: AW] = a; ch_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
    ram_done = 0; ram_ready = 1; ram_rdata = '0;
  endtask

  // asynchronous reset: outputs must already be zero before any edge
  task automatic do_reset();
    reset = 1; clear_inputs();
    #1;
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ch_done", ch_done, 0);
    chk("rst_ch_rdata", ch_rdata, 0);
    @(posedge clock);
    #1;
    reset = 0; model_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    clear_inputs(); model_reset();
    @(posedge clock); #1;
    chk("init_ready", ch_ready, 4'hF);
    do_reset();
    // single read with 2-cycle RAM latency
    set_req(0, 1, 0, 16'h1000, 0);
    tick();
    chk("t1_addr", ram_address, 16'h1000);
    chk("t1_read", ram_read, 1);
    tick(); tick();
    ram_done = 1; ram_rdata = 32'hA5A5A5A5;
    tick();
    ram_done = 0;
    chk("t1_done", ch_done, 4'b0001);
    chk("t1_rdata", ch_rdata, 32'hA5A5A5A5);
    chk("t1_cmd_low", ram_read, 0);
    set_req(0, 0, 0, 0, 0);
    tick();
    chk("t1_ready", ch_ready, 4'hF);
    // rr_ptr now 1: channel 1 wins over channel 0
    set_req(0, 1, 0, 16'h2000, 0); set_req(1, 1, 0, 16'h3000, 0);
    tick();
    chk("ptr1_addr", ram_address, 16'h3000);
    ram_done = 1; tick(); ram_done = 0;
    chk("ptr1_done", ch_done, 4'b0010);
    set_req(1, 0, 0, 0, 0);
    tick(); tick();
    chk("ptr1_next", ram_address, 16'h2000);
    ram_done = 1; tick(); ram_done = 0;
    chk("ptr1_done0", ch_done, 4'b0001);
    set_req(0, 0, 0, 0, 0);
    tick();
    // contention from reset
    do_reset();
    set_req(0, 1, 0, 16'h0010, 0); set_req(1, 1, 0, 16'h0020, 0);
    tick();
    chk("cont_first", ram_address, 16'h0010);
    ram_done = 1; tick(); ram_done = 0;
    chk("cont_done0", ch_done, 4'b0001);
    set_req(0, 0, 0, 0, 0);
    tick(); tick();
    chk("cont_second", ram_address, 16'h0020);
    ram_done = 1; tick(); ram_done = 0;
    chk("cont_done1", ch_done, 4'b0010);
    set_req(1, 0, 0, 0, 0);
    tick();
    // fairness with every channel requesting continuously
    do_reset();
    for (int i = 0; i < C; i++) set_req(i, 1, 0, AW'(i * 16), DW'(i));
    done_log.delete();
    for (int n = 0; n < 40; n++) begin
      ram_done = ram_read | ram_write;
      tick();
    end
    for (int k = 0; k < 8; k++)
      chk("fair_order", k < done_log.size() ? 64'(done_log[k]) : 64'hFFFF, 64'(k % C));
    // back-pressure
    do_reset();
    ram_ready = 0;
    set_req(1, 0, 1, 16'h0040, 32'hDEADBEEF);
    repeat (5) begin
      tick();
      chk("bp_hold", ram_write, 0);
    end
    ram_ready = 1;
    tick();
    chk("bp_write", ram_write, 1);
    chk("bp_wdata", ram_wdata, 32'hDEADBEEF);
    ram_ready = 0;
    tick();
    chk("bp_busy_ignores_ready", ram_write, 1);
    ram_done = 1; tick(); ram_done = 0; ram_ready = 1;
    chk("bp_done", ch_done, 4'b0010);
    set_req(1, 0, 0, 0, 0);
    tick();
    // read/write conflict on one channel
    do_reset();
    set_req(0, 1, 1, 16'h0077, 32'h12345678);
    tick();
    chk("conf_read", ram_read, 1);
    chk("conf_write", ram_write, 0);
    ram_done = 1; ram_rdata = 32'h0BADCAFE; tick(); ram_done = 0;
    set_req(0, 0, 0, 0, 0);
    tick();
    // reset while BUSY
    do_reset();
    set_req(1, 1, 0, 16'h0011, 0);
    tick();
    ram_done = 1; ram_rdata = 32'h55550000; tick(); ram_done = 0;
    set_req(1, 0, 0, 0, 0);
    tick();
    set_req(2, 1, 0, 16'h0022, 32'hCAFEF00D);
    tick();
    chk("rb_read", ram_read, 1);
    chk("rb_rdata_before", ch_rdata, 32'h55550000);
    do_reset();
    chk("rb_no_done", ch_done, 0);
    set_req(1, 1, 0, 16'h0101, 0); set_req(3, 1, 0, 16'h0303, 0);
    tick();
    chk("rb_ptr0", ram_address, 16'h0101);
    ram_done = 1; tick(); ram_done = 0;
    clear_inputs();
    tick();
    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < C; i++) pending[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < C; i++) begin
        if (m_done == i) begin
          pending[i] = 0; set_req(i, 0, 0, 0, 0);
        end else if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1; r = $urandom_range(0, 2);
          set_req(i, r != 1, r != 0, AW'($urandom), $urandom);
        end
      end
      ram_ready = $urandom_range(0, 3) != 0;
      ram_done = m_act ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      ram_rdata = $urandom;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
